// File: rtl/tcp_pkg.sv
// Shared TCP engine widths and the enqueue length type.
package tcp_pkg;
  localparam int unsigned FLOWID_W         = 8;
  localparam int unsigned TX_PAYLOAD_PTR_W = 14;

  // Lengths and pointers both carry one wrap bit above the buffer index.
  typedef logic [TX_PAYLOAD_PTR_W:0] enq_len_t;
endpackage

// File: rtl/payload_enq_ctrl_if.sv
// Enqueue request/response, head/tail pointer read ports and tail write port.
interface payload_enq_ctrl_if;
  import tcp_pkg::*;

  logic                enq_req_val;
  logic                enq_req_rdy;
  logic [FLOWID_W-1:0] enq_req_flowid;
  enq_len_t            enq_req_len;

  logic                enq_resp_val;
  logic                enq_resp_rdy;
  logic [FLOWID_W-1:0] enq_resp_flowid;
  logic                enq_resp_ok;
  enq_len_t            enq_resp_ptr;

  logic                head_rd_req_val;
  logic                head_rd_req_rdy;
  logic [FLOWID_W-1:0] head_rd_req_flowid;
  logic                head_rd_resp_val;
  logic                head_rd_resp_rdy;
  enq_len_t            head_rd_resp_data;

  logic                tail_rd_req_val;
  logic                tail_rd_req_rdy;
  logic [FLOWID_W-1:0] tail_rd_req_flowid;
  logic                tail_rd_resp_val;
  logic                tail_rd_resp_rdy;
  enq_len_t            tail_rd_resp_data;

  logic                tail_wr_req_val;
  logic                tail_wr_req_rdy;
  logic [FLOWID_W-1:0] tail_wr_req_flowid;
  enq_len_t            tail_wr_req_data;

  modport master (
    input  enq_req_val, enq_req_flowid, enq_req_len,
    output enq_req_rdy,
    output enq_resp_val, enq_resp_flowid, enq_resp_ok, enq_resp_ptr,
    input  enq_resp_rdy,
    output head_rd_req_val, head_rd_req_flowid, head_rd_resp_rdy,
    input  head_rd_req_rdy, head_rd_resp_val, head_rd_resp_data,
    output tail_rd_req_val, tail_rd_req_flowid, tail_rd_resp_rdy,
    input  tail_rd_req_rdy, tail_rd_resp_val, tail_rd_resp_data,
    output tail_wr_req_val, tail_wr_req_flowid, tail_wr_req_data,
    input  tail_wr_req_rdy
  );

  modport slave (
    output enq_req_val, enq_req_flowid, enq_req_len,
    input  enq_req_rdy,
    input  enq_resp_val, enq_resp_flowid, enq_resp_ok, enq_resp_ptr,
    output enq_resp_rdy,
    input  head_rd_req_val, head_rd_req_flowid, head_rd_resp_rdy,
    output head_rd_req_rdy, head_rd_resp_val, head_rd_resp_data,
    input  tail_rd_req_val, tail_rd_req_flowid, tail_rd_resp_rdy,
    output tail_rd_req_rdy, tail_rd_resp_val, tail_rd_resp_data,
    input  tail_wr_req_val, tail_wr_req_flowid, tail_wr_req_data,
    output tail_wr_req_rdy
  );
endinterface

// File: rtl/payload_enq_ctrl.sv
// Appends payload bytes to a flow's TX buffer: reads head/tail, checks free
// space, advances the tail and reports the old tail. One request in flight.
module payload_enq_ctrl
  import tcp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  payload_enq_ctrl_if.master bus
);

  localparam int unsigned P   = TX_PAYLOAD_PTR_W;
  localparam logic [P+1:0] CAP = {2'b01, {P{1'b0}}};

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                req_rdy_q, req_rdy_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  enq_len_t            len_q, len_d;
  enq_len_t            head_q, head_d;
  enq_len_t            tail_q, tail_d;
  logic                head_got_q, head_got_d;
  logic                tail_got_q, tail_got_d;
  logic                head_req_q, head_req_d;
  logic                tail_req_q, tail_req_d;
  logic                head_rsp_rdy_q, head_rsp_rdy_d;
  logic                tail_rsp_rdy_q, tail_rsp_rdy_d;
  logic                ok_q, ok_d;
  logic                wr_val_q, wr_val_d;
  enq_len_t            wr_data_q, wr_data_d;
  logic                resp_val_q, resp_val_d;

  logic                head_fire, tail_fire;
  enq_len_t            head_cur, tail_cur, used;
  logic [P+1:0]        sum;
  logic                fits;

  assign head_fire = head_rsp_rdy_q & bus.head_rd_resp_val;
  assign tail_fire = tail_rsp_rdy_q & bus.tail_rd_resp_val;

  // The final response may be captured in the same cycle the decision is made.
  assign head_cur = head_got_q ? head_q : bus.head_rd_resp_data;
  assign tail_cur = tail_got_q ? tail_q : bus.tail_rd_resp_data;
  assign used     = tail_cur - head_cur;
  assign sum      = {1'b0, used} + {1'b0, len_q};
  assign fits     = ({1'b0, used} <= CAP) && (sum <= CAP);

  always_comb begin
    state_d        = state_q;
    req_rdy_d      = req_rdy_q;
    flowid_d       = flowid_q;
    len_d          = len_q;
    head_d         = head_q;
    tail_d         = tail_q;
    head_got_d     = head_got_q;
    tail_got_d     = tail_got_q;
    head_req_d     = head_req_q;
    tail_req_d     = tail_req_q;
    head_rsp_rdy_d = head_rsp_rdy_q;
    tail_rsp_rdy_d = tail_rsp_rdy_q;
    ok_d           = ok_q;
    wr_val_d       = wr_val_q;
    wr_data_d      = wr_data_q;
    resp_val_d     = resp_val_q;

    if (head_fire) begin
      head_d         = bus.head_rd_resp_data;
      head_got_d     = 1'b1;
      head_rsp_rdy_d = 1'b0;
    end
    if (tail_fire) begin
      tail_d         = bus.tail_rd_resp_data;
      tail_got_d     = 1'b1;
      tail_rsp_rdy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        req_rdy_d = 1'b1;
        if (bus.enq_req_val && req_rdy_q) begin
          req_rdy_d  = 1'b0;
          flowid_d   = bus.enq_req_flowid;
          len_d      = bus.enq_req_len;
          head_req_d = 1'b1;
          tail_req_d = 1'b1;
          head_got_d = 1'b0;
          tail_got_d = 1'b0;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        // Each read port completes independently; a response may arrive
        // while the other request is still stalled.
        if (head_req_q && bus.head_rd_req_rdy) begin
          head_req_d     = 1'b0;
          head_rsp_rdy_d = 1'b1;
        end
        if (tail_req_q && bus.tail_rd_req_rdy) begin
          tail_req_d     = 1'b0;
          tail_rsp_rdy_d = 1'b1;
        end
        if ((!head_req_q || bus.head_rd_req_rdy) &&
            (!tail_req_q || bus.tail_rd_req_rdy))
          state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if ((head_got_q || head_fire) && (tail_got_q || tail_fire)) begin
          ok_d = fits;
          if (fits && (len_q != '0)) begin
            wr_val_d  = 1'b1;
            wr_data_d = tail_cur + len_q;
            state_d   = WR;
          end else begin
            resp_val_d = 1'b1;
            state_d    = RESP;
          end
        end
      end
      WR: begin
        if (bus.tail_wr_req_rdy) begin
          wr_val_d   = 1'b0;
          resp_val_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.enq_resp_rdy) begin
          resp_val_d = 1'b0;
          req_rdy_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_rdy_q      <= 1'b0;
      flowid_q       <= '0;
      len_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      head_got_q     <= 1'b0;
      tail_got_q     <= 1'b0;
      head_req_q     <= 1'b0;
      tail_req_q     <= 1'b0;
      head_rsp_rdy_q <= 1'b0;
      tail_rsp_rdy_q <= 1'b0;
      ok_q           <= 1'b0;
      wr_val_q       <= 1'b0;
      wr_data_q      <= '0;
      resp_val_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_rdy_q      <= req_rdy_d;
      flowid_q       <= flowid_d;
      len_q          <= len_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      head_got_q     <= head_got_d;
      tail_got_q     <= tail_got_d;
      head_req_q     <= head_req_d;
      tail_req_q     <= tail_req_d;
      head_rsp_rdy_q <= head_rsp_rdy_d;
      tail_rsp_rdy_q <= tail_rsp_rdy_d;
      ok_q           <= ok_d;
      wr_val_q       <= wr_val_d;
      wr_data_q      <= wr_data_d;
      resp_val_q     <= resp_val_d;
    end
  end

  assign bus.enq_req_rdy        = req_rdy_q;
  assign bus.enq_resp_val       = resp_val_q;
  assign bus.enq_resp_flowid    = flowid_q;
  assign bus.enq_resp_ok        = ok_q;
  assign bus.enq_resp_ptr       = tail_q;
  assign bus.head_rd_req_val    = head_req_q;
  assign bus.head_rd_req_flowid = flowid_q;
  assign bus.head_rd_resp_rdy   = head_rsp_rdy_q;
  assign bus.tail_rd_req_val    = tail_req_q;
  assign bus.tail_rd_req_flowid = flowid_q;
  assign bus.tail_rd_resp_rdy   = tail_rsp_rdy_q;
  assign bus.tail_wr_req_val    = wr_val_q;
  assign bus.tail_wr_req_flowid = flowid_q;
  assign bus.tail_wr_req_data   = wr_data_q;

endmodule

// File: tb/tb_payload_enq_ctrl.sv
// Directed bench for payload_enq_ctrl with pointer RAM models and a
// free-space model predicting every tail write and enqueue response.
module tb_payload_enq_ctrl;
  import tcp_pkg::*;

  localparam int BUF = 2 ** TX_PAYLOAD_PTR_W;
  localparam int MOD = 2 * BUF;

  typedef struct { int f; int d; } wr_t;
  typedef struct { int f; int ok; int ptr; } rsp_t;

  logic clk;
  logic rst;
  payload_enq_ctrl_if bus ();

  payload_enq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;

  int ram_head [256];
  int ram_tail [256];
  int mdl_head [256];
  int mdl_tail [256];
  wr_t  wq [$];
  rsp_t rq [$];

  int head_extra = 0;
  int t_req_hold = 0;
  int wr_hold = 0;
  int resp_hold = 0;

  int cyc = 0, acc_cyc = 0, wr_cyc = 0, resp_cyc = 0, rdy_cyc = 0;
  int wr_cnt = 0, resp_done = 0, obs_ok = 0, obs_ptr = 0;
  int wr_stall_n = 0, resp_stall_n = 0;
  int cur_flow = 0;

  function automatic void chk(input string n, input int a, input int e);
    checks++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endfunction

  // Free-space rule on plain integers, modulo twice the buffer size.
  function automatic void predict(input int f, input int len);
    int h, t, used;
    int ok;
    h = mdl_head[f];
    t = mdl_tail[f];
    used = (t - h + MOD) % MOD;
    ok = (used <= BUF && used + len <= BUF) ? 1 : 0;
    if (ok == 1 && len != 0) begin
      wq.push_back('{f, (t + len) % MOD});
      mdl_tail[f] = (t + len) % MOD;
    end
    rq.push_back('{f, ok, t});
  endfunction

  task automatic setp(input int f, input int h, input int t);
    ram_head[f] = h; ram_tail[f] = t;
    mdl_head[f] = h; mdl_tail[f] = t;
  endtask

  initial begin : head_ram
    int cnt, addr, a_s;
    bit fq, fr, rs;
    cnt = -1; addr = 0;
    bus.head_rd_req_rdy = 1'b1;
    bus.head_rd_resp_val = 1'b0;
    bus.head_rd_resp_data = '0;
    forever begin
      @(negedge clk);
      fq = bus.head_rd_req_val && bus.head_rd_req_rdy;
      fr = bus.head_rd_resp_val && bus.head_rd_resp_rdy;
      a_s = int'(bus.head_rd_req_flowid);
      rs = rst;
      @(posedge clk); #1;
      if (rs) begin
        cnt = -1; bus.head_rd_resp_val = 1'b0;
      end else begin
        if (fr) bus.head_rd_resp_val = 1'b0;
        if (fq) begin addr = a_s; cnt = head_extra; end
        else if (cnt > 0) cnt--;
        if (cnt == 0) begin
          bus.head_rd_resp_val = 1'b1;
          bus.head_rd_resp_data = enq_len_t'(ram_head[addr]);
          cnt = -1;
        end
      end
    end
  end

  initial begin : tail_ram
    int cnt, addr, a_s;
    bit fq, fr, rs;
    cnt = -1; addr = 0;
    bus.tail_rd_req_rdy = 1'b1;
    bus.tail_rd_resp_val = 1'b0;
    bus.tail_rd_resp_data = '0;
    forever begin
      @(negedge clk);
      fq = bus.tail_rd_req_val && bus.tail_rd_req_rdy;
      fr = bus.tail_rd_resp_val && bus.tail_rd_resp_rdy;
      a_s = int'(bus.tail_rd_req_flowid);
      rs = rst;
      if (bus.tail_rd_req_val && !bus.tail_rd_req_rdy && t_req_hold > 0) t_req_hold--;
      @(posedge clk); #1;
      bus.tail_rd_req_rdy = (t_req_hold == 0);
      if (rs) begin
        cnt = -1; bus.tail_rd_resp_val = 1'b0;
      end else begin
        if (fr) bus.tail_rd_resp_val = 1'b0;
        if (fq) begin addr = a_s; cnt = 0; end
        if (cnt == 0) begin
          bus.tail_rd_resp_val = 1'b1;
          bus.tail_rd_resp_data = enq_len_t'(ram_tail[addr]);
          cnt = -1;
        end
      end
    end
  end

  initial begin : rdy_ctrl
    bus.tail_wr_req_rdy = 1'b1;
    bus.enq_resp_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.tail_wr_req_val && !bus.tail_wr_req_rdy && wr_hold > 0) wr_hold--;
      if (bus.enq_resp_val && !bus.enq_resp_rdy && resp_hold > 0) resp_hold--;
      @(posedge clk); #1;
      bus.tail_wr_req_rdy = (wr_hold == 0);
      bus.enq_resp_rdy = (resp_hold == 0);
    end
  end

  initial begin : compare
    bit rst_prev, busy, rdy_seen;
    rst_prev = 1'b0; busy = 1'b0; rdy_seen = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 1'b0;
        if (rst_prev) begin
          chk("rst_enq_req_rdy", int'(bus.enq_req_rdy), 0);
          chk("rst_enq_resp_val", int'(bus.enq_resp_val), 0);
          chk("rst_head_rd_val", int'(bus.head_rd_req_val), 0);
          chk("rst_tail_rd_val", int'(bus.tail_rd_req_val), 0);
          chk("rst_tail_wr_val", int'(bus.tail_wr_req_val), 0);
        end
      end else begin
        if (busy) chk("enq_req_rdy_busy", int'(bus.enq_req_rdy), 0);
        if (!busy && bus.enq_req_rdy && !rdy_seen) begin rdy_cyc = cyc; rdy_seen = 1'b1; end
        if (bus.enq_req_val && bus.enq_req_rdy) begin
          busy = 1'b1; rdy_seen = 1'b0; acc_cyc = cyc;
          cur_flow = int'(bus.enq_req_flowid);
        end
        if (bus.head_rd_req_val) chk("head_rd_flowid", int'(bus.head_rd_req_flowid), cur_flow);
        if (bus.tail_rd_req_val) chk("tail_rd_flowid", int'(bus.tail_rd_req_flowid), cur_flow);
        if (bus.tail_wr_req_val) begin
          if (!bus.tail_wr_req_rdy) wr_stall_n++;
          if (wq.size() == 0) chk("unexpected_tail_wr", 1, 0);
          else begin
            chk("tail_wr_flowid", int'(bus.tail_wr_req_flowid), wq[0].f);
            chk("tail_wr_data", int'(bus.tail_wr_req_data), wq[0].d);
            if (bus.tail_wr_req_rdy) begin
              ram_tail[wq[0].f] = int'(bus.tail_wr_req_data);
              void'(wq.pop_front());
              wr_cnt++; wr_cyc = cyc;
            end
          end
        end
        if (bus.enq_resp_val) begin
          if (!bus.enq_resp_rdy) resp_stall_n++;
          if (rq.size() == 0) chk("unexpected_enq_resp", 1, 0);
          else begin
            chk("resp_flowid", int'(bus.enq_resp_flowid), rq[0].f);
            chk("resp_ok", int'(bus.enq_resp_ok), rq[0].ok);
            chk("resp_ptr", int'(bus.enq_resp_ptr), rq[0].ptr);
            if (bus.enq_resp_rdy) begin
              obs_ok = int'(bus.enq_resp_ok);
              obs_ptr = int'(bus.enq_resp_ptr);
              void'(rq.pop_front());
              busy = 1'b0; resp_done++; resp_cyc = cyc;
            end
          end
        end
      end
      rst_prev = rst;
    end
  end

  task automatic issue(input int f, input int len);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    bus.enq_req_val = 1'b1;
    bus.enq_req_flowid = FLOWID_W'(f);
    bus.enq_req_len = enq_len_t'(len);
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.enq_req_rdy;
    end
    @(posedge clk); #1;
    bus.enq_req_val = 1'b0;
    chk("accept_in_time", int'(acc), 1);
  endtask

  task automatic enq(input int f, input int len, input int exp_ok,
                     input int exp_ptr, input int exp_tail);
    int r0;
    bit got;
    predict(f, len);
    r0 = resp_done;
    issue(f, len);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (resp_done != r0);
    end
    chk("resp_in_time", int'(got), 1);
    @(negedge clk);
    chk("lit_ok", obs_ok, exp_ok);
    chk("lit_ptr", obs_ptr, exp_ptr);
    chk("lit_ram_tail", ram_tail[f], exp_tail);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int w0, r0, save;
    bit got;
    rst = 1'b1;
    bus.enq_req_val = 1'b0;
    bus.enq_req_flowid = '0;
    bus.enq_req_len = '0;
    for (int i = 0; i < 256; i++) setp(i, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_rdy_after_reset", int'(bus.enq_req_rdy), 1);

    // Basic append plus pipeline timing with all rdy high.
    setp(1, 0, 0);
    enq(1, 100, 1, 0, 100);
    chk("lat_write", wr_cyc - acc_cyc, 3);
    chk("lat_resp", resp_cyc - acc_cyc, 4);
    repeat (2) @(negedge clk);
    chk("lat_next_rdy", rdy_cyc - acc_cyc, 5);

    // Exactly full, then one byte over.
    setp(2, 0, 16000);
    w0 = wr_cnt;
    enq(2, 384, 1, 16000, 16384);
    enq(2, 1, 0, 16384, 16384);
    chk("full_write_count", wr_cnt - w0, 1);

    // Pointer wrap.
    setp(4, 32700, 32760);
    enq(4, 20, 1, 32760, 12);

    // Zero length with a late head response.
    head_extra = 5;
    setp(6, 50, 80);
    w0 = wr_cnt;
    enq(6, 0, 1, 80, 80);
    chk("len0_no_write", wr_cnt - w0, 0);
    head_extra = 0;

    // Back-to-back on one flow sees the updated tail.
    setp(3, 0, 0);
    enq(3, 100, 1, 0, 100);
    enq(3, 50, 1, 100, 150);

    // Stalled tail read request.
    t_req_hold = 3;
    setp(5, 10, 20);
    enq(5, 7, 1, 20, 27);

    // Stalled write and response.
    wr_stall_n = 0; resp_stall_n = 0;
    wr_hold = 10; resp_hold = 3;
    setp(7, 0, 1000);
    enq(7, 24, 1, 1000, 1024);
    chk("wr_stall_cycles", wr_stall_n, 10);
    chk("resp_stall_cycles", resp_stall_n, 3);

    // Reset while stalled in the write: transaction is dropped.
    setp(9, 0, 500);
    save = mdl_tail[9];
    wr_hold = 1000;
    w0 = wr_cnt; r0 = resp_done;
    predict(9, 10);
    issue(9, 10);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.tail_wr_req_val;
    end
    chk("wr_reached", int'(got), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    wq.delete(); rq.delete();
    mdl_tail[9] = save;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_hold = 0;
    @(negedge clk);
    chk("abort_wr_val", int'(bus.tail_wr_req_val), 0);
    chk("abort_resp_val", int'(bus.enq_resp_val), 0);
    @(negedge clk);
    chk("abort_idle_rdy", int'(bus.enq_req_rdy), 1);
    repeat (20) @(negedge clk);
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_no_resp", resp_done - r0, 0);
    chk("abort_ram_tail", ram_tail[9], 500);

    // Normal service after the abort; fills to exactly the buffer size.
    setp(8, 100, 200);
    enq(8, 16284, 1, 200, 16484);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/payload_enq_ctrl.md
PAYLOAD_ENQ_CTRL -- requirements
Module: payload_enq_ctrl

Interface
REQ-001 SHALL use clock and reset as follows: one clock; reset is synchronous and active-high.
REQ-002 SHALL take no parameters; FLOWID_W and TX_PAYLOAD_PTR_W (P) come from tcp_pkg.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 enq_req_val / enq_req_rdy  in / out  1  enqueue request handshake.
REQ-006 enq_req_flowid / enq_req_len  in  FLOWID_W / P+1  flow; bytes to append.
REQ-007 enq_resp_val / enq_resp_rdy  out / in  1  response handshake.
REQ-008 enq_resp_flowid / enq_resp_ok / enq_resp_ptr  out  FLOWID_W / 1 / P+1  flow; accepted; old tail pointer.
REQ-009 head_rd_req_val / head_rd_req_rdy  out / in  1  head-pointer read request handshake.
REQ-010 head_rd_req_flowid  out  FLOWID_W  head read address.
REQ-011 head_rd_resp_val / head_rd_resp_rdy  in / out  1  head read response handshake.
REQ-012 head_rd_resp_data  in  P+1  head pointer.
REQ-013 tail_rd_req_val, tail_rd_req_flowid, tail_rd_req_rdy, tail_rd_resp_val, tail_rd_resp_data, tail_rd_resp_rdy: same as REQ-009..012, for the tail pointer.
REQ-014 tail_wr_req_val / tail_wr_req_rdy  out / in  1  tail write handshake.
REQ-015 tail_wr_req_flowid / tail_wr_req_data  out  FLOWID_W / P+1  write address; new tail.

Function
REQ-016 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR, RESP with one request outstanding.
REQ-017 IDLE: enq_req_rdy=1 only here; on val&rdy latch flowid and len, then go to RD_REQ.
REQ-018 RD_REQ: assert head_rd_req_val and tail_rd_req_val; drop each independently after its own handshake; move to RD_WAIT once both are done, including when both complete in the same cycle.
REQ-019 RD_WAIT: assert each *_rd_resp_rdy until that response is captured; once both are captured, evaluate REQ-020..022 in the same cycle.
REQ-020 Arithmetic mod 2^(P+1): used = tail - head; ok = (used <= 2^P) and (used + len <= 2^P), evaluated with a P+2-bit sum so there is no overflow.
REQ-021 If ok and len != 0: go to WR; otherwise go to RESP with no write.
REQ-022 len == 0 SHALL give ok=1 with no write; len == free space SHALL be accepted; len == free+1 SHALL be rejected.
REQ-023 WR: hold tail_wr_req_val with data = (tail + len) mod 2^(P+1) until rdy; tolerate unbounded stall (new-flow priority); then go to RESP.
REQ-024 RESP: hold enq_resp_val with flowid, ok, and ptr = captured old tail until rdy; then go to IDLE.
REQ-025 All request/response outputs SHALL be driven from registers, with no combinational in-to-out paths except the rdy-gated state advance.
REQ-026 With all rdy=1 and a 1-cycle RAM response: accept at t, read request at t+1, capture at t+2, write at t+3, response at t+4, next accept at t+5.
REQ-027 A following request to the same flow SHALL observe the updated tail, since the write completes before RESP.

Reset
REQ-028 While rst=1: state=IDLE, all *_val outputs=0, enq_req_rdy=0, capture flags cleared, data registers=0.
REQ-029 Reset mid-operation SHALL abort the transaction; no tail write and no response SHALL be issued afterwards.

Structure
REQ-030 No new package entries; the state enum SHALL be local to the module; an enq length typedef (P+1 bits) MAY be added to tcp_pkg.
REQ-031 No sub-module; the block sits beside payload_pointers, driving its read port 1 and tail write port.

Verification (P=14, buffer 16384)
REQ-032 head=0, tail=0, len=100 -> write tail=100; resp ok=1, ptr=0.
REQ-033 head=0, tail=16000, len=384 -> ok=1, tail=16384; then len=1 -> ok=0, no write.
REQ-034 Wrap: head=32700, tail=32760, len=20 -> ok=1, new tail=12 (mod 32768), ptr=32760.
REQ-035 len=0 -> ok=1, tail_wr_req_val never asserts; head resp delayed 5 cycles after tail resp -> correct capture.
REQ-036 tail_wr_req_rdy=0 for 10 cycles and enq_resp_rdy=0 for 3 -> values held stable, enq_req_rdy=0 throughout; rst pulsed in WR -> no write, IDLE next cycle.
